// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: fetch FSM encoding, opcode constants and reset defaults.
// Imported by the fetch unit and by the control unit that decodes if_opcode.
package mips_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_FETCH = 2'd0;
    localparam fetch_state_t ST_VALID = 2'd1;
    localparam fetch_state_t ST_DRAIN = 2'd2;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding-request fetch stage: owns the PC, talks req/ack to instruction memory
// and hands one instruction at a time to decode over valid/ready, with redirect squashing.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [5:0]       if_opcode,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc_plus4,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t     state, state_next;
    logic [31:0]      pc, pc_next;
    logic [31:0]      stale_addr, stale_addr_next;
    logic [31:0]      instr_next;
    logic [31:0]      if_pc_next;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      redirect_target;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        stale_addr_next = stale_addr;
        instr_next      = if_instr;
        if_pc_next      = if_pc;
        count_next      = fetch_count;

        case (state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    instr_next = INSTR_NOP;
                    if (imem_ack) begin
                        state_next = ST_FETCH;
                    end else begin
                        // Request is already on the bus; keep presenting its address until ack.
                        stale_addr_next = pc;
                        state_next      = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    instr_next = imem_rdata;
                    if_pc_next = pc;
                    pc_next    = pc + 32'd4;
                    state_next = ST_VALID;
                end
            end

            ST_VALID: begin
                if (if_ready) begin
                    count_next = fetch_count + CNT_ONE;
                end
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    instr_next = INSTR_NOP;
                    state_next = ST_FETCH;
                end else if (if_ready) begin
                    state_next = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    instr_next = INSTR_NOP;
                end
                if (imem_ack) begin
                    state_next = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            stale_addr  <= RESET_PC;
            if_instr    <= INSTR_NOP;
            if_pc       <= 32'h0000_0000;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            stale_addr  <= stale_addr_next;
            if_instr    <= instr_next;
            if_pc       <= if_pc_next;
            fetch_count <= count_next;
        end
    end

    // Request is masked during reset so memory never sees a fetch from stale state.
    assign imem_req    = !rst && ((state == ST_FETCH) || (state == ST_DRAIN));
    assign imem_addr   = (state == ST_DRAIN) ? stale_addr : pc;
    assign if_valid    = (state == ST_VALID);
    assign if_opcode   = if_instr[31:26];
    assign if_pc_plus4 = if_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: memory responder with variable latency,
// program-order PC model, and a monitor that checks every accepted instruction.
module tb_instr_fetch_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          if_valid;
    logic          if_ready;
    logic [31:0]   if_instr;
    logic [5:0]    if_opcode;
    logic [31:0]   if_pc;
    logic [31:0]   if_pc_plus4;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] fetch_count;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;

    int lat_min   = 0;
    int lat_max   = 0;
    int ready_pct = 100;
    int redir_pct = 0;
    int force_mode = 0;
    logic [31:0] force_tgt = 32'h0;

    logic [31:0]   exp_pc  = 32'h0;
    logic [CW-1:0] exp_cnt = '0;

    // Memory contents as a bijective function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Memory responder: latches the request address, acks after a random delay.
    initial begin : responder
        bit          busy;
        int          cnt;
        logic [31:0] lat_addr;
        busy       = 1'b0;
        cnt        = 0;
        lat_addr   = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (busy) begin
                check("imem_req held", 32'(imem_req), 32'd1);
                check("imem_addr held", imem_addr, lat_addr);
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(lat_addr);
                    busy       = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (imem_req) begin
                lat_addr = imem_addr;
                cnt      = $urandom_range(lat_min, lat_max);
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(lat_addr);
                end else begin
                    busy = 1'b1;
                    cnt--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks hold/squash behaviour.
    initial begin : monitor
        logic        prev_valid, prev_ready, prev_redir;
        logic [31:0] prev_pc, prev_instr, op_word;
        exp_t        e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_redir = 1'b0;
        prev_pc    = 32'h0;
        prev_instr = 32'h0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (if_valid && if_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected accept: got pc %h, expected none", if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        op_word = e.instr;
                        check("if_pc", if_pc, e.pc);
                        check("if_instr", if_instr, e.instr);
                        check("if_opcode", 32'(if_opcode), 32'(op_word[31:26]));
                        check("if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
                        check("fetch_count", 32'(fetch_count), 32'(e.cnt));
                    end
                end
                if (prev_redir) begin
                    check("squash if_valid", 32'(if_valid), 32'd0);
                    if (prev_valid) check("squash if_instr", if_instr, 32'h0);
                end else if (prev_valid && !prev_ready) begin
                    check("hold if_valid", 32'(if_valid), 32'd1);
                    check("hold if_pc", if_pc, prev_pc);
                    check("hold if_instr", if_instr, prev_instr);
                end
                if (if_valid) check("no req in valid", 32'(imem_req), 32'd0);
            end
            prev_valid = if_valid;
            prev_ready = if_ready;
            prev_redir = redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end
    end

    // One stimulus cycle; pushes the expected record for every handshake it issues.
    task automatic cycle();
        logic        rv, acc;
        logic [31:0] tgt;
        @(negedge clk);
        #1;
        if_ready = (int'($urandom_range(0, 99)) < ready_pct);
        #1;
        tgt = $urandom;
        rv  = 1'b0;
        case (force_mode)
            1:       rv = imem_req && !imem_ack;
            2:       rv = imem_req && imem_ack;
            3:       rv = if_valid && if_ready;
            default: rv = (int'($urandom_range(0, 99)) < redir_pct);
        endcase
        if (rv && force_mode != 0) begin
            tgt        = force_tgt;
            force_mode = 0;
        end
        redirect_valid = rv;
        redirect_pc    = tgt;
        acc = if_valid && if_ready;
        if (acc) begin
            exp_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc), cnt: exp_cnt});
            exp_cnt = exp_cnt + 1'b1;
            n_acc++;
        end
        if (rv) exp_pc = tgt & 32'hFFFF_FFFC;
        else if (acc) exp_pc = exp_pc + 32'd4;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic directed_redirect(input int mode, input logic [31:0] tgt, input string name);
        force_mode = mode;
        force_tgt  = tgt;
        run(30);
        check(name, 32'(force_mode), 32'd0);
        force_mode = 0;
    endtask

    initial begin
        rst            = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        check("reset imem_req", 32'(imem_req), 32'd0);
        check("reset if_valid", 32'(if_valid), 32'd0);
        check("reset if_instr", if_instr, 32'h0);
        check("reset if_pc", if_pc, 32'h0);
        check("reset fetch_count", 32'(fetch_count), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("first imem_addr", imem_addr, 32'h0);
        check("first imem_req", 32'(imem_req), 32'd1);

        // Latency 1, always ready: sequential stream from 0.
        lat_min = 0; lat_max = 0; ready_pct = 100; redir_pct = 0;
        run(12);
        // Latency 3 with decode stalled, then released.
        lat_min = 2; lat_max = 2; ready_pct = 0;
        run(10);
        ready_pct = 100;
        run(10);
        // Redirect while waiting for ack, coincident with ack, and in VALID with ready.
        directed_redirect(1, 32'h0000_0103, "redirect while waiting");
        lat_min = 1; lat_max = 2;
        directed_redirect(2, 32'h0000_2000, "redirect with ack");
        directed_redirect(3, 32'h0000_3000, "redirect in valid");
        // Fetch at the top of the address space wraps to 0.
        directed_redirect(1, 32'hFFFF_FFFC, "redirect to top");
        run(20);

        lat_min = 0; lat_max = 3; ready_pct = 60; redir_pct = 8;
        run(1500);

        redir_pct = 0; ready_pct = 0;
        run(8);
        @(negedge clk);
        #3;
        check("final fetch_count", 32'(fetch_count), 32'(exp_cnt));
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        check("enough accepts", 32'(n_acc >= 100), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
